// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single memory port between the CPU FSM (m0) and
// the debug/DMA master (m1); one outstanding transaction, watchdog abort on a silent memory.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [2:0]    m0_op,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [2:0]    m1_op,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [2:0]    mem_op,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | port free, arbitrate between pending requests
    // BUSY  | mem_req held, waiting for mem_ready or watchdog expiry
    // RESP  | done (and err on timeout) pulse to the owner
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic          we_q, we_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        wd_d    = wd_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        pick    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // on a tie the master that lost last time wins
                    pick    = (m0_req && m1_req) ? ~last_q : m1_req;
                    owner_d = pick;
                    last_d  = pick;
                    err_d   = 1'b0;
                    wd_d    = '0;
                    we_d    = pick ? m1_we    : m0_we;
                    op_d    = pick ? m1_op    : m0_op;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        if (owner_q) rd1_d = mem_rdata;
                        else         rd0_d = mem_rdata;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        if (owner_q) rd1_d = '0;
                        else         rd0_d = '0;
                    end
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign m0_gnt   = (state_q != IDLE) && !owner_q;
    assign m1_gnt   = (state_q != IDLE) &&  owner_q;
    assign m0_done  = (state_q == RESP) && !owner_q;
    assign m1_done  = (state_q == RESP) &&  owner_q;
    assign m0_err   = m0_done && err_q;
    assign m1_err   = m1_done && err_q;
    assign m0_rdata = rd0_q;
    assign m1_rdata = rd1_q;

endmodule
